// File: rtl/irq_pending_reg.sv
// irq_pending_reg: rising-edge capture of 8 request lines into sticky, maskable pending bits
// with per-line overflow flags. Define IRQ_SYNC_EN to add a 2-flop synchronizer on req_in.
module irq_pending_reg (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req_in,
   input  logic       mask_we,
   input  logic [7:0] mask_in,
   input  logic       ack,
   input  logic [2:0] ack_idx,
   output logic [7:0] pend_out,
   output logic       any_pend,
   output logic [3:0] pend_cnt,
   output logic [7:0] ovf_out
);
   localparam int unsigned NL = 8;
   localparam int unsigned CW = 4;

   logic [NL-1:0] req_s;
   logic [NL-1:0] req_q;
   logic [NL-1:0] pending;
   logic [NL-1:0] mask;
   logic [NL-1:0] ovf;
   logic [NL-1:0] rise;
   logic [NL-1:0] ack_vec;
   logic [NL-1:0] ack_clr;
   logic [NL-1:0] ovf_set;
   logic [NL-1:0] pending_nxt;
   logic [NL-1:0] ovf_nxt;

`ifdef IRQ_SYNC_EN
   logic [NL-1:0] sync_1;
   logic [NL-1:0] sync_2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= '0;
         sync_2 <= '0;
      end else begin
         sync_1 <= req_in;
         sync_2 <= sync_1;
      end
   end

   assign req_s = sync_2;
`else
   assign req_s = req_in;
`endif

   // A new event beats a same-cycle ack of its line; ack only takes effect without an edge.
   always_comb begin
      rise        = req_s & ~req_q;
      ack_vec     = ack ? (NL'(1) << ack_idx) : '0;
      ack_clr     = ack_vec & ~rise;
      ovf_set     = rise & pending & ~ack_vec;
      pending_nxt = (pending | rise) & ~ack_clr;
      ovf_nxt     = (ovf | ovf_set) & ~ack_clr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= '0;
         pending <= '0;
         mask    <= '0;
         ovf     <= '0;
      end else begin
         req_q   <= req_s;
         pending <= pending_nxt;
         ovf     <= ovf_nxt;
         if (mask_we) begin
            mask <= mask_in;
         end
      end
   end

   assign pend_out = pending & mask;
   assign any_pend = |pend_out;
   assign ovf_out  = ovf;

   always_comb begin
      pend_cnt = '0;
      for (int i = 0; i < NL; i++) begin
         pend_cnt = pend_cnt + CW'(pend_out[i]);
      end
   end
endmodule

// File: doc/irq_pending_reg.md
# irq_pending_reg

Request-capture stage placed directly upstream of the 8-to-3 priority encoder. Detects rising edges on eight asynchronous-origin request lines, latches each as a sticky pending bit, applies a programmable enable mask and presents the masked pending vector to the encoder. A consumer acknowledges the serviced index, which clears that bit. Per-line overflow flags record events that arrive while the same line is already pending.

## Interface
- No parameters; width fixed at 8 lines / 3-bit index.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_in`  in  8  request lines; a 0→1 transition is one event.
- `mask_we`  in  1  write strobe for the mask register.
- `mask_in`  in  8  new mask value; bit=1 enables the line.
- `ack`  in  1  consumer has serviced `ack_idx`; one-cycle pulse.
- `ack_idx`  in  3  index being acknowledged.
- `pend_out`  out  8  `pending & mask`; drives the encoder's `a_in`.
- `any_pend`  out  1  OR of `pend_out`.
- `pend_cnt`  out  4  population count of `pend_out`, 0..8.
- `ovf_out`  out  8  sticky per-line overflow flags; unmasked.

## Operation
- Registers:
  - `req_q[7:0]`: previous sampled request.
  - `pending[7:0]`
  - `mask[7:0]`
  - `ovf[7:0]`
- Edge detect: `edge = req_s & ~req_q`, where `req_s` is `req_in`, or the synchronizer output when enabled. `req_q <= req_s` every cycle.
- Per bit i, every edge, in priority order:
  - `edge[i]` and `pending[i]` already 1 and no clearing ack for i → `ovf[i] <= 1`; `pending[i]` stays 1.
  - `edge[i]` → `pending[i] <= 1`. A new event wins over a simultaneous ack of the same bit; `ovf[i]` is not set in that case.
  - `ack && ack_idx==i` → `pending[i] <= 0`, `ovf[i] <= 0`.
  - Otherwise hold.
- Ack of a non-pending index: no effect, no error.
- Masked lines still latch pending and overflow; they are only hidden from `pend_out`, `any_pend` and `pend_cnt`. Unmasking later exposes them immediately.
- `mask_we`: `mask <= mask_in` at the edge. Outputs reflect the new mask from the following cycle.
- `pend_out`, `any_pend` and `pend_cnt` are combinational from registered `pending` and `mask` only, with no input-to-output paths.
- Reset values: `req_q`=0, `pending`=0, `mask`=8'h00 (all disabled), `ovf`=0, synchronizer flops=0.
  - Hence `pend_out`=0, `any_pend`=0, `pend_cnt`=0, `ovf_out`=0.
- A line held high through reset release registers exactly one event on the first sampling edge, because `req_q` resets to 0.
- Reset asserted mid-operation clears all state immediately; no events are retained.

## Timing
- Without synchronizer: `req_in` rising before edge N sets `pending` at edge N, so `pend_out` is valid after N (1-cycle latency).
- With synchronizer: pending is set at edge N+2 (3-cycle latency).
- Ack at edge N: bit cleared after N, so the encoder sees the next winner in the following cycle.
- A request must stay low for at least one sampled cycle between events to be counted as distinct. Two synchronizer-stage cycles are required when the synchronizer is enabled.
- Mask write at edge N is visible after N.

## Configuration
- `IRQ_SYNC_EN`
  - Defined: each `req_in` bit passes through a 2-flop synchronizer before edge detect. Latency becomes 3 cycles. Synchronizer flops reset to 0.
  - Undefined: `req_in` feeds edge detect directly. Latency is 1 cycle; inputs must be synchronous to `clk`.

## Test plan
- Reset, then `mask`=8'hFF, pulse `req_in[5]` → `pend_out`=8'h20, `any_pend`=1, `pend_cnt`=1 after 1 cycle (3 cycles with `IRQ_SYNC_EN`). Then `ack`, `ack_idx`=5 → `pend_out`=0 next cycle.
- `mask`=8'h0F, pulse `req_in[7]` and `req_in[1]` together → `pend_out`=8'h02, `pend_cnt`=1. Then write `mask`=8'hFF → `pend_out`=8'h82, `pend_cnt`=2.
- `pending[3]`=1, second rising edge on `req_in[3]` → `ovf_out`=8'h08, `pending[3]` still 1. Then ack idx 3 → `ovf_out`=0, `pend_out[3]`=0.
- Rising edge on `req_in[2]` in the same cycle as `ack`, `ack_idx`=2 with `pending[2]`=1 → `pending[2]` remains 1, `ovf_out[2]`=0.
- `req_in`=8'hFF held constant across reset release, `mask`=8'hFF → `pend_out`=8'hFF once. Ack all eight indices → `pend_out`=0 and stays 0 while `req_in` is held high.
- Four lines pending, assert `rst_n`=0 mid-cycle → all outputs read 0 immediately, without waiting for a clock edge. Ack of idx 6 while nothing is pending → no output change.
